ahb_port_arbiter: RTL

//   Shares the single AHB_MASTER request port between the instruction fetch unit (IF) and the load/store unit (LS).

---
 rtl/ahb_port_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/ahb_port_arbiter.sv
// Shares one AHB master request port between instruction fetch (IF) and load/store (LS).
// LS has fixed priority; a starvation counter forces an IF grant; one transfer outstanding.
module ahb_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_ready_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_wr_i,
  input  logic [1:0]            ls_size_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_ready_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  input  logic                  flush_i,
  output logic                  bus_req_o,
  output logic                  bus_wr_o,
  output logic [1:0]            bus_size_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_ready_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StIfBusy, StLsBusy} state_e;

  state_e                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_drop;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_slot, w_starved, w_gnt_if, w_gnt_ls, w_if_done, w_ls_done;

  // Gating with rst_n_i keeps the combinational grants low while reset is held.
  assign w_slot    = rst_n_i & ((r_state == StIdle) | bus_ready_i);
  assign w_starved = (r_cnt == CNT_WIDTH'(STARVE_LIMIT));
  assign w_gnt_if  = w_slot & if_req_i & ~flush_i & (~ls_req_i | w_starved);
  assign w_gnt_ls  = w_slot & ls_req_i & ~w_gnt_if;
  assign w_if_done = (r_state == StIfBusy) & bus_ready_i;
  assign w_ls_done = (r_state == StLsBusy) & bus_ready_i;

  assign if_gnt_o    = w_gnt_if;
  assign ls_gnt_o    = w_gnt_ls;
  // A flush landing in the completion cycle also discards that fetch.
  assign if_ready_o  = w_if_done & ~r_drop & ~flush_i;
  assign ls_ready_o  = w_ls_done;
  assign if_rdata_o  = (r_state == StIfBusy) ? bus_rdata_i : '0;
  assign ls_rdata_o  = (r_state == StLsBusy) ? bus_rdata_i : '0;
  assign busy_o      = (r_state != StIdle);
  assign bus_req_o   = busy_o;
  assign bus_wr_o    = r_wr;
  assign bus_size_o  = r_size;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_gnt_if) begin
        r_state <= StIfBusy;
        r_wr    <= 1'b0;
        r_size  <= 2'd2;
        r_addr  <= if_addr_i;
        r_wdata <= '0;
      end else if (w_gnt_ls) begin
        r_state <= StLsBusy;
        r_wr    <= ls_wr_i;
        r_size  <= ls_size_i;
        r_addr  <= ls_addr_i;
        r_wdata <= ls_wdata_i;
      end else if (w_slot) begin
        r_state <= StIdle;
      end

      if (w_if_done) begin
        r_drop <= 1'b0;
      end else if ((r_state == StIfBusy) && flush_i) begin
        r_drop <= 1'b1;
      end

      // Counts LS wins while IF is waiting; saturates at the limit.
      if (!if_req_i || w_gnt_if) begin
        r_cnt <= '0;
      end else if (w_gnt_ls && !w_starved) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
